bus_router: RTL and testbench
=============================

BUS_ROUTER -- requirements
Module: bus_router

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- S0_REGION, 4'h0, address[31:28] value selecting slave 0.
- S1_REGION, 4'h1, selector for slave 1.
- S2_REGION, 4'h2, selector for slave 2.
- S3_REGION, 4'h5, selector for slave 3.
- TIMEOUT_CYCLES, 16'd255, watchdog limit in ACTIVE.
REQ-002 SHALL have ports (name, direction, width, meaning); clock is i_clock, reset is asynchronous active-low i_reset_n:
- i_clock, in, 1, clock.
- i_reset_n, in, 1, async reset, active low.
- i_bus_rw, in, 1, 1 = write.
- i_bus_request, in, 1, master request.
- o_bus_ready, out, 1, transfer complete pulse.
- i_bus_address, in, 32, address.
- o_bus_rdata, out, 32, read data.
- i_bus_wdata, in, 32, write data.
- o_bus_error, out, 1, error pulse coincident with o_bus_ready.
- o_s_rw, out, 1, shared slave rw.
- o_s_address, out, 32, shared slave address.
- o_s_wdata, out, 32, shared slave wdata.
- o_s_request, out, 4, one-hot slave request.
- i_s_ready, in, 4, slave ready.
- i_s_rdata, in, 128, slave n data at [32n+31:32n].
- o_fault, out, 1, sticky fault flag.
- o_fault_address, out, 32, address of first fault.
- i_fault_clear, in, 1, clears o_fault.

Function
REQ-003 SHALL implement FSM states IDLE, ACTIVE and ERROR.
REQ-004 In IDLE with i_bus_request=1, SHALL decode i_bus_address[31:28]: a match registers one-hot select and enters ACTIVE; no match enters ERROR.
REQ-005 If region selectors overlap, the lowest slave index SHALL win.
REQ-006 o_s_request SHALL be registered: select bit high throughout ACTIVE, zero in IDLE and ERROR.
REQ-007 o_s_rw, o_s_address and o_s_wdata SHALL pass combinationally from the master inputs at all times.
REQ-008 In ACTIVE, o_bus_ready SHALL equal i_s_ready of the selected slave, combinationally, and o_bus_rdata SHALL equal that slave's rdata.
- The state returns to IDLE on the next edge.
- Ready and rdata from unselected slaves SHALL be ignored.
REQ-009 Outside a completing cycle, o_bus_rdata SHALL be 32'h0.
REQ-010 Latency: request sampled at edge N; o_s_request high after edge N; earliest o_bus_ready is in cycle N+1.
REQ-011 ERROR SHALL last exactly one cycle:
- o_bus_ready=1, o_bus_error=1, o_bus_rdata=32'h0.
- Then return to IDLE.
REQ-012 If i_bus_request falls in ACTIVE before ready, the transfer SHALL abort: IDLE on the next edge, slave request dropped, no ready.
REQ-013 A request still high in IDLE on the cycle after completion SHALL start a new transfer (back-to-back allowed).
REQ-014 On ERROR entry (and on timeout when enabled), o_fault SHALL set and o_fault_address SHALL capture i_bus_address, but only if o_fault is already 0.
REQ-015 i_fault_clear SHALL clear o_fault; a simultaneous new fault SHALL take precedence (flag stays set, address updated).

Reset
REQ-016 i_reset_n=0 SHALL immediately, independent of the clock:
- force state to IDLE;
- zero o_s_request, o_fault, o_fault_address and the watchdog counter.
REQ-017 Reset mid-transfer SHALL drop the slave request without issuing o_bus_ready.
REQ-018 After reset release, the first edge with a request SHALL behave per REQ-004.

Configuration
REQ-019 Macro BUS_ROUTER_TIMEOUT_EN SHALL control the 16-bit ACTIVE watchdog.
- Defined: the counter clears on ACTIVE entry and increments each ACTIVE cycle without ready. When it equals TIMEOUT_CYCLES, the block SHALL behave per REQ-011 in that cycle (ready=1, error=1, rdata 0), drop the slave request, record a fault per REQ-014, and go to IDLE.
- Undefined: no counter; ACTIVE waits indefinitely.

Verification
REQ-020 Bench SHALL cover these scenarios:
- Read 0x1000_0040, slave1 ready after 3 cycles with rdata 0xCAFE_F00D -> o_s_request=4'b0010, o_bus_ready and rdata 0xCAFE_F00D in cycle N+3, error=0.
- Write 0x5000_0000 data 0x1234_5678 -> o_s_request=4'b1000, o_s_rw=1, o_s_wdata=0x1234_5678 until ready.
- Access 0x9000_0000 -> one-cycle ready+error, rdata 0, o_fault=1, o_fault_address=0x9000_0000. A second miss leaves the address unchanged; i_fault_clear clears the flag.
- Timeout enabled, TIMEOUT_CYCLES=8, slave0 never ready -> ready+error after 8 ACTIVE cycles, o_s_request=0 next cycle.
- i_reset_n low in ACTIVE -> o_s_request=0 immediately, no o_bus_ready; a subsequent read completes normally.
- Back-to-back reads to slave0 then slave2 with request held -> two ready pulses, each with the correct rdata.

Source files
------------

// File: rtl/bus_router.sv
// bus_router: single-master to four-slave address router with an IDLE/ACTIVE/ERROR
// transfer FSM and a sticky fault recorder. The slave is selected by address[31:28].
// Optional feature: define BUS_ROUTER_TIMEOUT_EN to add a 16-bit ACTIVE-state
// watchdog that ends a stalled transfer with an error after TIMEOUT_CYCLES cycles.
module bus_router #(
    parameter logic [3:0]  S0_REGION      = 4'h0,
    parameter logic [3:0]  S1_REGION      = 4'h1,
    parameter logic [3:0]  S2_REGION      = 4'h2,
    parameter logic [3:0]  S3_REGION      = 4'h5,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
    input  logic         i_clock,
    input  logic         i_reset_n,
    input  logic         i_bus_rw,
    input  logic         i_bus_request,
    output logic         o_bus_ready,
    input  logic [31:0]  i_bus_address,
    output logic [31:0]  o_bus_rdata,
    input  logic [31:0]  i_bus_wdata,
    output logic         o_bus_error,
    output logic         o_s_rw,
    output logic [31:0]  o_s_address,
    output logic [31:0]  o_s_wdata,
    output logic [3:0]   o_s_request,
    input  logic [3:0]   i_s_ready,
    input  logic [127:0] i_s_rdata,
    output logic         o_fault,
    output logic [31:0]  o_fault_address,
    input  logic         i_fault_clear
);

    typedef enum logic [1:0] {IDLE, ACTIVE, ERROR} state_t;

    state_t      state, state_next;
    logic [3:0]  request_next;
    logic [3:0]  decode;
    logic [31:0] sel_rdata;
    logic        hit;
    logic        timeout;
    logic        fault_event;

    // The slave side sees the master's command fields directly.
    assign o_s_rw      = i_bus_rw;
    assign o_s_address = i_bus_address;
    assign o_s_wdata   = i_bus_wdata;

    // Region decode; the if/else chain makes the lowest slave index win on overlap.
    always_comb begin
        decode = 4'b0000;
        if      (i_bus_address[31:28] == S0_REGION) decode = 4'b0001;
        else if (i_bus_address[31:28] == S1_REGION) decode = 4'b0010;
        else if (i_bus_address[31:28] == S2_REGION) decode = 4'b0100;
        else if (i_bus_address[31:28] == S3_REGION) decode = 4'b1000;
    end

    // Only the registered select may steer ready and read data back to the master.
    always_comb begin
        sel_rdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (o_s_request[i]) sel_rdata = sel_rdata | i_s_rdata[32*i +: 32];
        end
    end

    assign hit = (state == ACTIVE) && |(i_s_ready & o_s_request);

`ifdef BUS_ROUTER_TIMEOUT_EN
    logic [15:0] wd_count;

    // Watchdog: held at zero outside ACTIVE, counts ACTIVE cycles that see no ready.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)          wd_count <= 16'd0;
        else if (state != ACTIVE) wd_count <= 16'd0;
        else if (!hit)            wd_count <= wd_count + 16'd1;
    end

    assign timeout = (state == ACTIVE) && !hit && (wd_count == TIMEOUT_CYCLES);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout        = 1'b0;
`endif

    // Next-state and master-side response logic.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_next   = state;
        request_next = o_s_request;
        fault_event  = 1'b0;
        o_bus_ready  = 1'b0;
        o_bus_error  = 1'b0;
        o_bus_rdata  = 32'h0;
        unique case (state)
            IDLE: begin
                if (i_bus_request) begin
                    if (|decode) begin
                        state_next   = ACTIVE;
                        request_next = decode;
                    end else begin
                        state_next  = ERROR;
                        fault_event = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (!i_bus_request) begin
                    // Master withdrew: abort silently.
                    state_next   = IDLE;
                    request_next = 4'b0000;
                end else if (hit) begin
                    o_bus_ready  = 1'b1;
                    o_bus_rdata  = sel_rdata;
                    state_next   = IDLE;
                    request_next = 4'b0000;
                end else if (timeout) begin
                    o_bus_ready  = 1'b1;
                    o_bus_error  = 1'b1;
                    fault_event  = 1'b1;
                    state_next   = IDLE;
                    request_next = 4'b0000;
                end
            end
            ERROR: begin
                o_bus_ready = 1'b1;
                o_bus_error = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next   = IDLE;
                request_next = 4'b0000;
            end
        endcase
    end

    // State and slave select registers.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!i_reset_n) begin
            state       <= IDLE;
            o_s_request <= 4'b0000;
        end else begin
            state       <= state_next;
            o_s_request <= request_next;
        end
    end

    // Sticky fault recorder: a new fault wins over a simultaneous clear.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_fault         <= 1'b0;
            o_fault_address <= 32'h0;
        end else if (fault_event && (!o_fault || i_fault_clear)) begin
            o_fault         <= 1'b1;
            o_fault_address <= i_bus_address;
        end else if (i_fault_clear) begin
            o_fault         <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_router.sv
// tb_bus_router: randomized and directed stimulus for bus_router. The driver pushes the
// expected completion (cycle, rdata, error) into a scoreboard; a negedge monitor pops
// and compares whenever o_bus_ready is seen. Fault state is tracked by a simple model.
module tb_bus_router;

    localparam int TMO = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rw = 1'b0, req = 1'b0, fclear = 1'b0;
    logic [31:0]  addr = 32'h0, wdata = 32'h0;
    logic [3:0]   s_ready = 4'h0;
    logic [127:0] s_rdata = 128'h0;

    logic         bus_ready, bus_error, s_rw, fault;
    logic [31:0]  bus_rdata, s_address, s_wdata, fault_address;
    logic [3:0]   s_request;

    bus_router #(.TIMEOUT_CYCLES(16'(TMO))) dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_bus_rw(rw), .i_bus_request(req),
        .o_bus_ready(bus_ready), .i_bus_address(addr), .o_bus_rdata(bus_rdata),
        .i_bus_wdata(wdata), .o_bus_error(bus_error), .o_s_rw(s_rw),
        .o_s_address(s_address), .o_s_wdata(s_wdata), .o_s_request(s_request),
        .i_s_ready(s_ready), .i_s_rdata(s_rdata), .o_fault(fault),
        .o_fault_address(fault_address), .i_fault_clear(fclear)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    // Reference fault model
    logic        m_flag = 1'b0;
    logic [31:0] m_addr = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int region_of(input logic [3:0] nib);
        logic [3:0] regions [4];
        regions = '{4'h0, 4'h1, 4'h2, 4'h5};
        for (int i = 0; i < 4; i++) if (nib == regions[i]) return i;
        return -1;
    endfunction

    function automatic void model_fault(input logic [31:0] a, input logic clr);
        if (!m_flag || clr) begin
            m_flag = 1'b1;
            m_addr = a;
        end
    endfunction

    // Monitor: every completion must match the head of the scoreboard.
    always @(negedge clk) begin
        if (bus_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", 32'(bus_ready), 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ready_cycle", 32'(cyc), 32'(e.cyc));
                check("rdata", bus_rdata, e.rdata);
                check("error", 32'(bus_error), 32'(e.err));
            end
        end else begin
            check("rdata_idle_zero", bus_rdata, 32'h0);
        end
    end

    task automatic check_fault();
        check("fault_flag", 32'(fault), 32'(m_flag));
        check("fault_addr", fault_address, m_addr);
    endtask

    task automatic check_pass(input logic [31:0] a, input logic w, input logic [31:0] wd);
        check("s_address", s_address, a);
        check("s_wdata", s_wdata, wd);
        check("s_rw", 32'(s_rw), 32'(w));
    endtask

    // One transfer; d = ACTIVE cycles before ready, d < 0 = slave never answers.
    task automatic txn(input logic [31:0] a, input logic w, input logic [31:0] wd,
                       input int d, input logic [31:0] rd);
        int idx;
        exp_t e;
        logic [3:0] onehot;
        int n;
        idx = region_of(a[31:28]);
        req = 1'b1; addr = a; rw = w; wdata = wd; s_ready = 4'h0;
        if (idx < 0) begin
            e.rdata = 32'h0; e.err = 1'b1; e.cyc = cyc + 1;
            sb.push_back(e);
            model_fault(a, fclear);
            @(posedge clk) #1;
            fclear = 1'b0;
            check("err_s_request", 32'(s_request), 32'h0);
            @(posedge clk) #1;
            check_fault();
        end else begin
            onehot = 4'(1 << idx);
            n = (d < 0) ? TMO : d;
            e.rdata = (d < 0) ? 32'h0 : rd; e.err = (d < 0); e.cyc = cyc + 1 + n;
            sb.push_back(e);
            @(posedge clk) #1;
            fclear = 1'b0;
            for (int k = 0; k < n; k++) begin
                check("s_request_wait", 32'(s_request), 32'(onehot));
                check_pass(a, w, wd);
                s_ready = 4'($urandom) & ~onehot;
                s_rdata = {$urandom, $urandom, $urandom, $urandom};
                @(posedge clk) #1;
            end
            if (d < 0) begin
                s_ready = 4'($urandom) & ~onehot;
                model_fault(a, 1'b0);
            end else begin
                s_ready = (4'($urandom) & ~onehot) | onehot;
                s_rdata = {$urandom, $urandom, $urandom, $urandom};
                s_rdata[32*idx +: 32] = rd;
            end
            check("s_request_done", 32'(s_request), 32'(onehot));
            check_pass(a, w, wd);
            @(posedge clk) #1;
            s_ready = 4'h0;
            check("s_request_after", 32'(s_request), 32'h0);
            check_fault();
        end
    endtask

    task automatic gap();
        req = 1'b0;
        @(posedge clk) #1;
    endtask

    task automatic fault_clear_pulse();
        req = 1'b0; fclear = 1'b1;
        @(posedge clk) #1;
        fclear = 1'b0;
        m_flag = 1'b0;
        check_fault();
    endtask

    initial begin
        #1;
        check("rst_s_request", 32'(s_request), 32'h0);
        check("rst_ready", 32'(bus_ready), 32'h0);
        check_fault();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk) #1;

        // Read from slave 1, ready in the third ACTIVE cycle.
        txn(32'h1000_0040, 1'b0, 32'h0, 2, 32'hCAFE_F00D);
        gap();
        // Write to slave 3.
        txn(32'h5000_0000, 1'b1, 32'h1234_5678, 3, 32'h0);
        gap();
        // Unmapped region, then a second miss that must not move the address.
        txn(32'h9000_0000, 1'b0, 32'h0, 0, 32'h0);
        gap();
        txn(32'hA000_0004, 1'b0, 32'h0, 0, 32'h0);
        gap();
        fault_clear_pulse();
        // New fault while clearing: the fault wins and the address updates.
        txn(32'hB000_0000, 1'b0, 32'h0, 0, 32'h0);
        gap();
        fclear = 1'b1;
        txn(32'hC000_0008, 1'b1, 32'h5555_AAAA, 0, 32'h0);
        gap();
        fault_clear_pulse();

`ifdef BUS_ROUTER_TIMEOUT_EN
        txn(32'h0000_0010, 1'b0, 32'h0, -1, 32'h0);
        gap();
        fault_clear_pulse();
`endif

        // Abort: request drops before ready.
        req = 1'b1; addr = 32'h2000_0000; rw = 1'b0;
        @(posedge clk) #1;
        check("abort_active", 32'(s_request), 32'h4);
        req = 1'b0; s_ready = 4'b1011;
        @(posedge clk) #1;
        s_ready = 4'h0;
        check("abort_dropped", 32'(s_request), 32'h0);
        @(posedge clk) #1;

        // Reset mid-transfer.
        txn(32'h9100_0000, 1'b0, 32'h0, 0, 32'h0);
        req = 1'b1; addr = 32'h1000_0100;
        @(posedge clk) #1;
        check("pre_reset_active", 32'(s_request), 32'h2);
        rst_n = 1'b0;
        #1;
        check("reset_s_request", 32'(s_request), 32'h0);
        check("reset_ready", 32'(bus_ready), 32'h0);
        m_flag = 1'b0; m_addr = 32'h0;
        check_fault();
        req = 1'b0;
        @(posedge clk) #1;
        rst_n = 1'b1;
        @(posedge clk) #1;
        txn(32'h1000_0200, 1'b0, 32'h0, 1, 32'h0BAD_BEEF);
        gap();

        // Back-to-back with request held.
        txn(32'h0000_0020, 1'b0, 32'h0, 0, 32'h1111_0000);
        txn(32'h2000_0030, 1'b0, 32'h0, 1, 32'h2222_0000);
        gap();

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            a = {4'($urandom_range(0, 15)), 28'($urandom)};
            txn(a, 1'($urandom), $urandom, int'($urandom_range(0, 4)), $urandom);
            if ($urandom_range(0, 7) == 0) fault_clear_pulse();
            else if ($urandom_range(0, 1) == 0) gap();
        end
        gap();

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
